ahb_slave_regfile: RTL and testbench
====================================

Name: ahb_slave_regfile

Overview:
- Downstream AHB-Lite slave that consumes the transfers issued by the AHB_BUS master stage: single-beat 32-bit word writes and reads to a small register file.
- Sits on the master's bus; decodes HSEL/HTRANS, runs the pipelined address/data phases and inserts programmable wait states.
- Optionally returns two-cycle ERROR responses for unmapped addresses.

Parameters:
- ADDR_W, 4, address width; word address, no byte lanes.
- DEPTH, 16, number of implemented 32-bit registers (1..2**ADDR_W).
- WAIT_STATES, 0, wait cycles inserted per data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_W  word address (address phase).
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read (address phase).
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready; previous transfer completing.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready; low = wait state.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (HRESET=1 at a clock edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all registers cleared to 0, wait counter 0.
- Reset mid-transfer abandons it; no register write occurs.
- Accept: address phase taken on an edge where HSEL & HTRANS[1] & HREADY. Latch addr_q, write_q; load wait counter with WAIT_STATES.
- HTRANS IDLE/BUSY, or HSEL=0: no transfer; zero-wait OKAY (HREADYOUT=1, HRESP=0).
- State machine: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> DATA on accept with WAIT_STATES=0.
  - IDLE -> WAIT on accept with WAIT_STATES>0.
  - WAIT: HREADYOUT=0; counter decrements each cycle; at count 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; this is the completing cycle.
    - Write: mem[addr_q] <= HWDATA at the end of this cycle.
    - Read: HRDATA = mem[addr_q] during this cycle.
  - From DATA: a new accept in the same cycle -> DATA or WAIT (back-to-back pipelining); otherwise -> IDLE.
- Latency: completion occurs WAIT_STATES+1 cycles after the address-phase edge.
- HRDATA is 0 outside a read DATA cycle.
- Read directly following a write to the same address returns the new data; the write commits at the end of its DATA cycle, before the read's DATA cycle.
- Address and control are ignored while HREADY=0. A transfer is accepted only when the previous one completes.
- Writes and reads to addr >= DEPTH without the optional feature: write discarded, read returns 0, OKAY response, normal wait states.

Optional Feature:
- Macro: AHB_SLV_ERR_EN.
- Defined: accepted addr >= DEPTH enters ERR1 (skips wait states).
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - ERR2 then goes to IDLE, or to DATA/WAIT/ERR1 on a new accept.
  - No write occurs; HRDATA=0.
- Undefined: ERR1/ERR2 not built, HRESP tied 0, unmapped access behaves as above.

Test Plan:
- Reset, then idle bus -> HREADYOUT=1, HRESP=0, HRDATA=0; read addr 3 returns 0x0.
- WAIT_STATES=0: NONSEQ write addr 5 data 30, then NONSEQ write addr 8 data 500 back-to-back, then read addr 8 -> HRDATA=500 in the cycle after the read address phase; read addr 5 -> 30.
- Read of addr 8 in the address phase immediately after its write data phase (data 0x12345678) -> HRDATA=0x12345678.
- WAIT_STATES=2: write addr 2 data 0xA5A5A5A5 -> HREADYOUT low exactly 2 cycles, write commits on the third cycle; readback returns 0xA5A5A5A5; HWDATA changes during the wait cycles are ignored until the final cycle.
- HTRANS=BUSY/IDLE with HSEL=1 and HWRITE=1 to addr 4 -> no write; addr 4 reads 0.
- Assert HRESET during a wait state of a write to addr 7 -> no write; all outputs at reset values next cycle.
- DEPTH=12 with AHB_SLV_ERR_EN: write addr 13 -> ERROR response (HREADYOUT 0 then 1, HRESP 1 for both cycles), no write.
- DEPTH=12 without AHB_SLV_ERR_EN: same write addr 13 -> OKAY response; read addr 13 returns 0.

Source files
------------

// File: rtl/ahb_slave_regfile.sv
// AHB-Lite slave in front of a word-addressed 32-bit register file with programmable wait states.
// Define AHB_SLV_ERR_EN to return two-cycle ERROR responses for addresses at or above DEPTH.
module ahb_slave_regfile #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int unsigned     Slots    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WaitInit = 4'(WAIT_STATES);

`ifdef AHB_SLV_ERR_EN
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWait = 3'd1,
        StData = 3'd2,
        StErr1 = 3'd3,
        StErr2 = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWait = 3'd1,
        StData = 3'd2
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       mem_q [Slots];

    logic accept;
    logic haddr_mapped;
    logic addr_mapped;
    logic can_take;
    logic ready;
    logic resp;
    logic wr_en;
    logic rd_en;
    logic unused_trans0;

    // Only NONSEQ/SEQ start a transfer, so the low HTRANS bit carries no information here.
    assign unused_trans0 = HTRANS[0];

    assign accept       = HSEL & HTRANS[1] & HREADY;
    assign haddr_mapped = {1'b0, HADDR} < DepthW;
    assign addr_mapped  = {1'b0, addr_q} < DepthW;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        ready    = 1'b1;
        resp     = 1'b0;
        can_take = 1'b0;

        case (state_q)
            StIdle: begin
                can_take = 1'b1;
            end
            StWait: begin
                ready = 1'b0;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StData;
                end
            end
            StData: begin
                can_take = 1'b1;
                state_d  = StIdle;
            end
`ifdef AHB_SLV_ERR_EN
            StErr1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = StErr2;
            end
            StErr2: begin
                resp     = 1'b1;
                can_take = 1'b1;
                state_d  = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new address phase is only taken in cycles that complete (or have no) prior transfer.
        if (can_take && accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            cnt_d   = WaitInit;
`ifdef AHB_SLV_ERR_EN
            if (!haddr_mapped) begin
                state_d = StErr1;
            end else if (WAIT_STATES == 0) begin
                state_d = StData;
            end else begin
                state_d = StWait;
            end
`else
            if (WAIT_STATES == 0) begin
                state_d = StData;
            end else begin
                state_d = StWait;
            end
`endif
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_en = (state_q == StData) && write_q && addr_mapped;
    assign rd_en = (state_q == StData) && !write_q && addr_mapped;

    // Slots at or above DEPTH are never written and stay zero after reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < Slots; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr_q] <= HWDATA;
        end
    end

    assign HRDATA    = rd_en ? mem_q[addr_q] : '0;
    assign HREADYOUT = ready;
    assign HRESP     = resp;

    wait_count_live : assert property (@(posedge HCLK) disable iff (HRESET)
        (state_q == StWait) |-> (cnt_q != 4'd0));

    rdata_only_on_read : assert property (@(posedge HCLK) disable iff (HRESET)
        (HRDATA != '0) |-> rd_en);

endmodule

// File: tb/tb_ahb_slave_regfile.sv
// Bench for ahb_slave_regfile: two instances (zero-wait full map, two-wait partial map) driven
// by a transaction-level master and checked against a per-instance array model of the registers.
module tb_ahb_slave_regfile;

    localparam int AW = 4;
    localparam int D0 = 16;
    localparam int W0 = 0;
    localparam int D1 = 12;
    localparam int W1 = 2;
`ifdef AHB_SLV_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit [AW-1:0] addr;
        bit          wr;
        bit [31:0]   data;
        bit          blk;
    } txn_t;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          blk;
    int            tgt;

    logic [31:0] rdata0, rdata1, rdata_m, rdata_o;
    logic        rdy0, rdy1, resp0, resp1, rdy_m, resp_m, rdy_o, resp_o;
    logic        sel0, sel1, hready0, hready1;

    logic [31:0] mdl [2][16];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          cur_v;
    txn_t        cur;

    always #5 HCLK = ~HCLK;

    assign sel0    = HSEL & (tgt == 0);
    assign sel1    = HSEL & (tgt == 1);
    assign hready0 = rdy0 & ~blk;
    assign hready1 = rdy1 & ~blk;
    assign rdy_m   = (tgt == 1) ? rdy1 : rdy0;
    assign resp_m  = (tgt == 1) ? resp1 : resp0;
    assign rdata_m = (tgt == 1) ? rdata1 : rdata0;
    assign rdy_o   = (tgt == 1) ? rdy0 : rdy1;
    assign resp_o  = (tgt == 1) ? resp0 : resp1;
    assign rdata_o = (tgt == 1) ? rdata0 : rdata1;

    ahb_slave_regfile #(.ADDR_W(AW), .DEPTH(D0), .WAIT_STATES(W0)) u_dut0 (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (sel0),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (hready0),
        .HRDATA    (rdata0),
        .HREADYOUT (rdy0),
        .HRESP     (resp0)
    );

    ahb_slave_regfile #(.ADDR_W(AW), .DEPTH(D1), .WAIT_STATES(W1)) u_dut1 (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (sel1),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (hready1),
        .HRDATA    (rdata1),
        .HREADYOUT (rdy1),
        .HRESP     (resp1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t tgt=%0d)", tag, got, exp, $time, tgt);
        end
    endtask

    // Targeted instance must match the expectation; the other one must look idle.
    task automatic sample(input string tag, input bit erdy, input bit eresp,
                          input logic [31:0] erd);
        check_eq({tag, "_rdy"}, 32'(rdy_m), 32'(erdy));
        check_eq({tag, "_resp"}, 32'(resp_m), 32'(eresp));
        check_eq({tag, "_rdata"}, rdata_m, erd);
        check_eq({tag, "_other_ctl"}, {30'd0, rdy_o, resp_o}, 32'd2);
        check_eq({tag, "_other_rdata"}, rdata_o, 32'd0);
    endtask

    function automatic txn_t mk(bit sel, bit [1:0] trans, bit [AW-1:0] addr, bit wr,
                                bit [31:0] data, bit blk_v);
        txn_t t;
        t.sel   = sel;
        t.trans = trans;
        t.addr  = addr;
        t.wr    = wr;
        t.data  = data;
        t.blk   = blk_v;
        return t;
    endfunction

    function automatic txn_t idle_txn();
        return mk(1'b0, 2'b00, '0, 1'b0, 32'd0, 1'b0);
    endfunction

    function automatic txn_t rnd_txn();
        return mk($urandom_range(0, 7) != 0, 2'($urandom), AW'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 7) == 0);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) begin
                mdl[i][j] = 32'd0;
            end
        end
    endtask

    // Finishes the transfer currently in its data phase and presents nxt as the next address phase.
    task automatic step(input txn_t nxt);
        int          d;
        int          w;
        int          low;
        bit          err;
        bit          mapped;
        logic [31:0] exp_rd;
        d      = (tgt == 1) ? D1 : D0;
        w      = (tgt == 1) ? W1 : W0;
        err    = 1'b0;
        mapped = 1'b0;
        if (cur_v) begin
            mapped = int'(cur.addr) < d;
            err    = ErrEn && !mapped;
            low    = err ? 1 : w;
            for (int k = 0; k < low; k++) begin
                @(negedge HCLK);
                sample("wait", 1'b0, err, 32'd0);
                HSEL   = 1'($urandom);
                HTRANS = 2'($urandom);
                HADDR  = AW'($urandom);
                HWRITE = 1'($urandom);
                HWDATA = $urandom;
                blk    = 1'($urandom);
                @(posedge HCLK);
            end
            exp_rd = (!cur.wr && mapped && !err) ? mdl[tgt][cur.addr] : 32'd0;
            @(negedge HCLK);
            sample(cur.wr ? "wdone" : "rdone", 1'b1, err, exp_rd);
            HWDATA = cur.wr ? cur.data : $urandom;
        end else begin
            @(negedge HCLK);
            sample("idle", 1'b1, 1'b0, 32'd0);
            HWDATA = $urandom;
        end
        HSEL   = nxt.sel;
        HTRANS = nxt.trans;
        HADDR  = nxt.addr;
        HWRITE = nxt.wr;
        blk    = nxt.blk;
        @(posedge HCLK);
        if (cur_v && cur.wr && mapped && !err) begin
            mdl[tgt][cur.addr] = cur.data;
        end
        cur_v = nxt.sel && nxt.trans[1] && !nxt.blk;
        cur   = nxt;
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = '0;
        blk    = 1'b0;
        tgt    = 0;
        cur_v  = 1'b0;
        cur    = idle_txn();
        clear_model();

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        sample("reset", 1'b1, 1'b0, 32'd0);
        HRESET = 1'b0;

        // Zero-wait instance: back-to-back writes, pipelined reads, read right after write.
        tgt = 0;
        step(mk(1, 2'b10, 4'd3, 0, 0, 0));
        step(mk(1, 2'b10, 4'd5, 1, 32'd30, 0));
        step(mk(1, 2'b10, 4'd8, 1, 32'd500, 0));
        step(mk(1, 2'b10, 4'd8, 0, 0, 0));
        step(mk(1, 2'b10, 4'd5, 0, 0, 0));
        step(mk(1, 2'b10, 4'd8, 1, 32'h1234_5678, 0));
        step(mk(1, 2'b10, 4'd8, 0, 0, 0));
        step(mk(1, 2'b01, 4'd4, 1, 32'hFFFF_0001, 0));
        step(mk(1, 2'b00, 4'd4, 1, 32'hFFFF_0002, 0));
        step(mk(1, 2'b10, 4'd4, 1, 32'hFFFF_0003, 1));
        step(mk(1, 2'b10, 4'd4, 0, 0, 0));
        step(idle_txn());

        // Two-wait, 12-deep instance: wait states, unmapped access, reset inside a wait state.
        tgt = 1;
        step(mk(1, 2'b10, 4'd2, 1, 32'hA5A5_A5A5, 0));
        step(mk(1, 2'b11, 4'd2, 0, 0, 0));
        step(mk(1, 2'b10, 4'd13, 1, 32'hCAFE_F00D, 0));
        step(mk(1, 2'b10, 4'd13, 0, 0, 0));
        step(mk(1, 2'b10, 4'd2, 0, 0, 0));
        step(idle_txn());
        step(mk(1, 2'b10, 4'd7, 1, 32'hDEAD_BEEF, 0));
        @(negedge HCLK);
        sample("rst_wait", 1'b0, 1'b0, 32'd0);
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        @(posedge HCLK);
        @(negedge HCLK);
        sample("rst_mid", 1'b1, 1'b0, 32'd0);
        HRESET = 1'b0;
        clear_model();
        cur_v = 1'b0;
        step(mk(1, 2'b10, 4'd7, 0, 0, 0));
        step(mk(1, 2'b10, 4'd2, 0, 0, 0));
        step(idle_txn());

        // Randomized traffic on each instance, flushed before switching target.
        for (int t = 0; t < 2; t++) begin
            tgt = t;
            for (int n = 0; n < 200; n++) begin
                step(rnd_txn());
            end
            step(idle_txn());
            for (int a = 0; a < 16; a++) begin
                step(mk(1, 2'b10, AW'(a), 0, 0, 0));
            end
            step(idle_txn());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
